mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Sequences the single-ported unified memory and shares it between two requesters: instruction fetch (read-only) and the data-memory stage (LD/ST/STU, read or write).
- Sits between the fetch and memory stages and the memory model.
- Grants one access at a time and counts a fixed memory latency.
- Returns read data with a one-cycle done pulse, and drives stall to each requester while its request is pending.

Parameters:
MEM_LAT, 2, cycles from mem_en to valid mem_rdata; legal range 1..15 (4-bit counter)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
if_req  in  1  fetch read request, held high until if_done
if_addr  in  16  fetch address
if_rdata  out  16  fetch read data, valid while if_done=1
if_done  out  1  one-cycle completion pulse for fetch
if_stall  out  1  fetch must hold
dm_req  in  1  data request, held high until dm_done
dm_wr  in  1  1=write (from memWrt), 0=read
dm_addr  in  16  data address
dm_wdata  in  16  write data
dm_rdata  out  16  data read data, valid while dm_done=1
dm_done  out  1  one-cycle completion pulse for data
dm_stall  out  1  data stage must hold
mem_en  out  1  one-cycle access strobe to memory
mem_wr  out  1  write qualifier, valid with mem_en
mem_addr  out  16  memory address, held for whole access
mem_wdata  out  16  memory write data, held for whole access
mem_rdata  in  16  memory read data, valid MEM_LAT cycles after mem_en
err  out  1  one-cycle error pulse

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset values:
  - State=IDLE, owner=FETCH, counter=0.
  - mem_en, mem_wr, if_done, dm_done and err are 0.
  - mem_addr, mem_wdata, if_rdata and dm_rdata are 0x0000.
- States:
  - IDLE -> ACCESS on a grant.
  - ACCESS -> WAIT.
  - WAIT -> DONE when counter==1.
  - DONE -> IDLE.
- IDLE grant: dm_req has fixed priority over if_req. On the edge where IDLE sees a request:
  - latch owner, addr, wr (forced 0 for fetch) and wdata into the mem_* registers;
  - set mem_en=1 for exactly one cycle (ACCESS);
  - load counter=MEM_LAT.
- WAIT: counter decrements each cycle. On the edge leaving WAIT, capture mem_rdata into the owner's rdata register (reads only).
- DONE: the owner's done=1 for exactly one cycle. No grant is made in DONE, so a requester still holding req that cycle is not re-granted.
- Latency and throughput:
  - request seen at edge N; mem_en high during cycle N+1; done high during cycle N+MEM_LAT+1;
  - back-to-back throughput is one access per MEM_LAT+2 cycles.
- Write access: dm_done pulses as for a read. dm_rdata keeps its previous value.
- Stall outputs (combinational): if_stall = if_req & ~if_done; dm_stall = dm_req & ~dm_done.
- Non-owner: a non-owner request arriving mid-access waits; its stall stays high.
- Held signals: mem_addr, mem_wr and mem_wdata hold from ACCESS through DONE. Request inputs are ignored outside IDLE (requester changes are not observed).
- Non-owner rdata/done: unchanged, 0.
- Reset mid-access: return to IDLE immediately, drop the access, no done pulse.
- Simultaneous requests in IDLE: data wins; fetch is served on the next IDLE.

Optional Feature:
- Macro ARB_ALIGN_CHK_EN.
- Defined:
  - A granted request with addr[0]=1 does not access memory (mem_en stays 0).
  - err=1 for one cycle and the owner's done=1 in the same cycle, one cycle after the grant edge.
  - Then IDLE; rdata unchanged.
- Undefined: odd addresses are passed through unchanged; err is tied 0.

Test Plan:
1. MEM_LAT=2, if_req=1 with if_addr=0x0010, memory returns 0xABCD -> mem_en high cycle 1 with mem_addr=0x0010, mem_wr=0; if_done high cycle 3 with if_rdata=0xABCD; if_stall high cycles 0-2.
2. if_req and dm_req both rise at cycle 0 (dm read, 0x0200) -> data is served first (dm_done cycle 3); fetch mem_en at cycle 5; if_done cycle 7.
3. dm_req=1, dm_wr=1, addr 0x0040, wdata 0x1234 -> single mem_en with mem_wr=1 and mem_wdata=0x1234; dm_done cycle 3; dm_rdata unchanged.
4. rst asserted in WAIT -> next cycle state IDLE and all outputs at reset values; no done pulse; a new if_req is then served normally.
5. MEM_LAT=5, fetch read -> if_done exactly 6 cycles after the request edge; back-to-back fetches are 7 cycles apart.
6. ARB_ALIGN_CHK_EN defined, dm_addr=0x0003 -> mem_en never asserts; err and dm_done high together in cycle 1. Undefined: a normal access occurs with err=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Sequences a single-ported memory between instruction fetch and the data stage.
// Define ARB_ALIGN_CHK_EN to reject odd-address requests with an err pulse instead of accessing memory.
module mem_arbiter #(
  parameter int unsigned MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_done,
  output logic        if_stall,
  input  logic        dm_req,
  input  logic        dm_wr,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_wdata,
  output logic [15:0] dm_rdata,
  output logic        dm_done,
  output logic        dm_stall,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} stateT;
  typedef enum logic {FETCH, DATA} ownerT;

  localparam logic [3:0] LAT_CNT = 4'(MEM_LAT);

  stateT       state;
  ownerT       owner;
  logic [3:0]  counter;
  logic        anyReq;
  logic [15:0] grantAddr;
  logic        misaligned;

  // Data stage has fixed priority over fetch whenever both are asking.
  assign anyReq    = dm_req | if_req;
  assign grantAddr = dm_req ? dm_addr : if_addr;
  assign if_stall  = if_req & ~if_done;
  assign dm_stall  = dm_req & ~dm_done;

`ifdef ARB_ALIGN_CHK_EN
  logic errQ;
  assign misaligned = grantAddr[0];
  assign err        = errQ;
`else
  assign misaligned = 1'b0;
  assign err        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= FETCH;
      counter   <= '0;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_done   <= 1'b0;
      dm_done   <= 1'b0;
`ifdef ARB_ALIGN_CHK_EN
      errQ      <= 1'b0;
`endif
    end else begin
      mem_en  <= 1'b0;
      if_done <= 1'b0;
      dm_done <= 1'b0;
`ifdef ARB_ALIGN_CHK_EN
      errQ    <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (anyReq) begin
            owner     <= dm_req ? DATA : FETCH;
            mem_addr  <= grantAddr;
            mem_wr    <= dm_req & dm_wr;
            mem_wdata <= dm_req ? dm_wdata : '0;
            // A rejected access skips memory and completes straight through DONE.
            if (misaligned) begin
              state   <= DONE;
              if_done <= ~dm_req;
              dm_done <= dm_req;
`ifdef ARB_ALIGN_CHK_EN
              errQ    <= 1'b1;
`endif
            end else begin
              state   <= ACCESS;
              mem_en  <= 1'b1;
              counter <= LAT_CNT;
            end
          end
        end
        ACCESS, WAIT: begin
          counter <= counter - 4'd1;
          if (counter == 4'd1) begin
            state <= DONE;
            if (owner == DATA) begin
              dm_done <= 1'b1;
              if (!mem_wr) dm_rdata <= mem_rdata;
            end else begin
              if_done  <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end else begin
            state <= WAIT;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
